// File: rtl/subleq_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : subleq_mem_stage
// Function : Subleq execute/memory stage; reads mem[A], mem[B] over a 64-bit
//            MMU port, writes mem[B]-mem[A] and reports branch/next PC.
//            Optional: SUBLEQ_SAME_OPERAND_EN skips the second read when A and
//            B name the same word.
// Revision : 1.0 - initial release
// ============================================================================
module subleq_mem_stage #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] op_a,
    input  logic [ADDR_W-1:0] op_b,
    input  logic [ADDR_W-1:0] op_c,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] target,
    output logic [31:0]       result,
    output logic              mmu_en,
    output logic              mmu_we,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [7:0]        mmu_be_n,
    output logic [63:0]       mmu_wdata,
    input  logic [63:0]       mmu_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Operand addresses are word aligned, so only bits [ADDR_W-1:2] are kept
    logic [ADDR_W-1:2]   r_op_a;
    logic [ADDR_W-1:2]   r_op_b;
    logic [ADDR_W-1:0]   r_op_c;
    logic [ADDR_W-1:0]   r_pc_next;
    logic                r_same;
    logic [31:0]         r_word_a;
    logic [31:0]         r_result;
    logic                r_branch;
    logic [ADDR_W-1:0]   r_target;

    logic                w_same_acc;
    logic [31:0]         w_rd_word_a;
    logic [31:0]         w_rd_word_b;
    logic [31:0]         w_opnd_a;
    logic [31:0]         w_opnd_b;
    logic [31:0]         w_diff;
    logic                w_taken;
    logic                w_unused_bits;

    assign w_unused_bits = ^{op_a[1:0], op_b[1:0]};

`ifdef SUBLEQ_SAME_OPERAND_EN
    assign w_same_acc = (op_a[ADDR_W-1:2] == op_b[ADDR_W-1:2]);
`else
    assign w_same_acc = 1'b0;
`endif

    assign w_rd_word_a = r_op_a[2] ? mmu_rdata[63:32] : mmu_rdata[31:0];
    assign w_rd_word_b = r_op_b[2] ? mmu_rdata[63:32] : mmu_rdata[31:0];

    // When the second read is skipped, the line in mmu_rdata during WR is A's
    assign w_opnd_a = r_same ? w_rd_word_a : r_word_a;
    assign w_opnd_b = r_same ? w_rd_word_a : w_rd_word_b;
    assign w_diff   = w_opnd_b - w_opnd_a;
    assign w_taken  = w_diff[31] | (w_diff == 32'd0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= '0;
            r_pc_next <= '0;
            r_same    <= 1'b0;
            r_word_a  <= 32'd0;
            r_result  <= 32'd0;
            r_branch  <= 1'b0;
            r_target  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a    <= op_a[ADDR_W-1:2];
                        r_op_b    <= op_b[ADDR_W-1:2];
                        r_op_c    <= op_c;
                        r_pc_next <= pc_next;
                        r_same    <= w_same_acc;
                    end
                end
                S_RD_B: r_word_a <= w_rd_word_a;
                S_WR: begin
                    r_result <= w_diff;
                    r_branch <= w_taken;
                    r_target <= w_taken ? r_op_c : r_pc_next;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mmu_en      = 1'b0;
        mmu_we      = 1'b0;
        mmu_addr    = '0;
        mmu_be_n    = 8'hFF;
        mmu_wdata   = 64'd0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_RD_A;
            end
            S_RD_A: begin
                mmu_en      = 1'b1;
                mmu_addr    = {r_op_a[ADDR_W-1:3], 3'b000};
                mmu_be_n    = 8'h00;
                w_state_nxt = r_same ? S_WR : S_RD_B;
            end
            S_RD_B: begin
                mmu_en      = 1'b1;
                mmu_addr    = {r_op_b[ADDR_W-1:3], 3'b000};
                mmu_be_n    = 8'h00;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                mmu_en      = 1'b1;
                mmu_we      = 1'b1;
                mmu_addr    = {r_op_b[ADDR_W-1:3], 3'b000};
                mmu_be_n    = r_op_b[2] ? 8'h0F : 8'hF0;
                mmu_wdata   = {w_diff, w_diff};
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign branch_taken = r_branch;
    assign target       = r_target;

endmodule
`default_nettype wire

// File: tb/tb_subleq_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_subleq_mem_stage
// Function : Directed self-checking bench for subleq_mem_stage with a small
//            byte-enabled 64-bit memory model behind the MMU port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subleq_mem_stage;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          resetb;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] op_a, op_b, op_c, pc_next;
    logic          out_valid;
    logic          out_ready;
    logic          branch_taken;
    logic [AW-1:0] target;
    logic [31:0]   result;
    logic          mmu_en, mmu_we;
    logic [AW-1:0] mmu_addr;
    logic [7:0]    mmu_be_n;
    logic [63:0]   mmu_wdata;
    logic [63:0]   mmu_rdata;

    int n_vec = 0;
    int n_err = 0;

    subleq_mem_stage #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_c         (op_c),
        .pc_next      (pc_next),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .branch_taken (branch_taken),
        .target       (target),
        .result       (result),
        .mmu_en       (mmu_en),
        .mmu_we       (mmu_we),
        .mmu_addr     (mmu_addr),
        .mmu_be_n     (mmu_be_n),
        .mmu_wdata    (mmu_wdata),
        .mmu_rdata    (mmu_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 64 lines, preload port shares the write process
    logic [63:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [63:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mmu_en && mmu_we) begin
            for (int i = 0; i < 8; i++)
                if (!mmu_be_n[i]) mem[mmu_addr[8:3]][8*i +: 8] <= mmu_wdata[8*i +: 8];
        end
        if (mmu_en && !mmu_we) mmu_rdata <= mem[mmu_addr[8:3]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [63:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    int          n_rd, n_wr, ov_cyc;
    logic        k1_rd;
    logic [15:0] k1_addr, wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;

    // k counts negedges after the acceptance edge; k=1 is cycle T0+1
    task automatic monitor();
        n_rd = 0; n_wr = 0; ov_cyc = 0; k1_rd = 1'b0; k1_addr = '0;
        wr_addr = '0; wr_be = 8'hFF; wr_data = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                k1_rd   = mmu_en && !mmu_we;
                k1_addr = mmu_addr;
            end
            if (mmu_en && !mmu_we) n_rd++;
            if (mmu_en && mmu_we) begin
                n_wr++;
                wr_addr = mmu_addr;
                wr_be   = mmu_be_n;
                wr_data = mmu_wdata;
            end
            if (out_valid) begin
                ov_cyc = k;
                break;
            end
        end
        if (ov_cyc == 0) check("timeout_out_valid", 64'd0, 64'd1);
    endtask

    task automatic accept_and_monitor();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        monitor();
    endtask

    task automatic drive(input logic [15:0] a, b, c, pc);
        op_a = a; op_b = b; op_c = c; pc_next = pc;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [15:0] a, b, c, pc);
        @(negedge clk);
        drive(a, b, c, pc);
        accept_and_monitor();
    endtask

    task automatic check_instr(input string t, input int erd, input int ecyc,
                               input logic [15:0] eaddr, input logic [7:0] ebe,
                               input logic [31:0] eres, input logic ebt,
                               input logic [15:0] etgt);
        check({t, "_reads"},    64'(n_rd),    64'(erd));
        check({t, "_writes"},   64'(n_wr),    64'd1);
        check({t, "_wr_addr"},  64'(wr_addr), 64'(eaddr));
        check({t, "_wr_be_n"},  64'(wr_be),   64'(ebe));
        check({t, "_wr_data"},  wr_data,      {eres, eres});
        check({t, "_ov_cycle"}, 64'(ov_cyc),  64'(ecyc));
        check({t, "_result"},   64'(result),  64'(eres));
        check({t, "_taken"},    64'(branch_taken), 64'(ebt));
        check({t, "_target"},   64'(target),  64'(etgt));
    endtask

    task automatic handshake(input string t);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({t, "_hs_out_valid"}, 64'(out_valid), 64'd0);
        check({t, "_hs_in_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_c = '0; pc_next = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_taken",     64'(branch_taken), 64'd0);
        check("rst_target",    64'(target),       64'd0);
        check("rst_result",    64'(result),       64'd0);
        check("rst_mmu_en",    64'(mmu_en),       64'd0);
        check("rst_mmu_we",    64'(mmu_we),       64'd0);
        check("rst_be_n",      64'(mmu_be_n),     64'hFF);
        check("rst_addr",      64'(mmu_addr),     64'd0);
        check("rst_wdata",     mmu_wdata,         64'd0);
        resetb = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        preload(6'd1, 64'h00000000_00000005);
        preload(6'd2, 64'h0000000C_DEADBEEF);
        preload(6'd0, 64'h00000003_00000009);
        preload(6'd6, 64'h11111111_00000001);
        preload(6'd7, 64'h22222222_80000000);
        preload(6'd4, 64'h33333333_0000002A);

        // Reset asserted during the write cycle of the first instruction
        @(negedge clk);
        drive(16'h0008, 16'h0014, 16'h0100, 16'h0040);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midwr_pre_write", 64'(mmu_en && mmu_we), 64'd1);
        #1 resetb = 1'b0;
        #1;
        check("midwr_mmu_en",    64'(mmu_en),    64'd0);
        check("midwr_be_n",      64'(mmu_be_n),  64'hFF);
        check("midwr_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check("midwr_in_ready",  64'(in_ready),  64'd1);
        check("midwr_mem_kept",  mem[2],         64'h0000000C_DEADBEEF);

        // 12 - 5 = 7, upper half of line 0x10
        issue(16'h0008, 16'h0014, 16'h0100, 16'h0040);
        check_instr("t1", 2, 4, 16'h0010, 8'h0F, 32'h00000007, 1'b0, 16'h0040);
        handshake("t1");
        check("t1_mem", mem[2], 64'h00000007_DEADBEEF);

        // 3 - 9 = -6, same line different halves
        issue(16'h0000, 16'h0004, 16'h0200, 16'h0044);
        check_instr("t2", 2, 4, 16'h0000, 8'h0F, 32'hFFFFFFFA, 1'b1, 16'h0200);

        // Backpressure with the next instruction already offered
        drive(16'h0030, 16'h0038, 16'h0300, 16'h0048);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid),    64'd1);
            check("bp_in_ready",  64'(in_ready),     64'd0);
            check("bp_mmu_en",    64'(mmu_en),       64'd0);
            check("bp_result",    64'(result),       64'hFFFFFFFA);
            check("bp_taken",     64'(branch_taken), 64'd1);
            check("bp_target",    64'(target),       64'h0200);
        end
        handshake("t2");
        check("t2_mem", mem[0], 64'hFFFFFFFA_00000009);

        // 0x80000000 - 1 wraps to 0x7FFFFFFF, accepted right after handshake
        accept_and_monitor();
        check("t3_first_rd",   64'(k1_rd),   64'd1);
        check("t3_first_addr", 64'(k1_addr), 64'h0030);
        check_instr("t3", 2, 4, 16'h0038, 8'hF0, 32'h7FFFFFFF, 1'b0, 16'h0048);
        handshake("t3");
        check("t3_mem", mem[7], 64'h22222222_7FFFFFFF);

        // A == B: 42 - 42 = 0
`ifdef SUBLEQ_SAME_OPERAND_EN
        issue(16'h0020, 16'h0020, 16'h0400, 16'h004C);
        check_instr("t4", 1, 3, 16'h0020, 8'hF0, 32'h00000000, 1'b1, 16'h0400);
`else
        issue(16'h0020, 16'h0020, 16'h0400, 16'h004C);
        check_instr("t4", 2, 4, 16'h0020, 8'hF0, 32'h00000000, 1'b1, 16'h0400);
`endif
        handshake("t4");
        check("t4_mem", mem[4], 64'h33333333_00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subleq_mem_stage.md
# subleq_mem_stage

Execute/memory stage of the pipelined Subleq core, directly upstream of the MMU. Accepts one decoded instruction (operand addresses A, B, jump target C, fall-through PC), reads mem[A] and mem[B] over the MMU's 64-bit byte-enabled port, and writes mem[B] − mem[A] back to B. It then hands the branch decision and next PC to the fetch/PC stage. Operands are 32-bit little-endian words packed two per 64-bit MMU line.

## Interface
- ADDR_W, 16, byte-address width of A, B, C, PC and mmu_addr

- clk  in  1  clock, rising edge
- resetb  in  1  asynchronous active-low reset
- in_valid  in  1  instruction available
- in_ready  out  1  stage can accept (high only in IDLE)
- op_a  in  ADDR_W  byte address of subtrahend word
- op_b  in  ADDR_W  byte address of minuend/destination word
- op_c  in  ADDR_W  branch target
- pc_next  in  ADDR_W  fall-through PC
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- branch_taken  out  1  result ≤ 0 (signed)
- target  out  ADDR_W  op_c if taken, else pc_next
- result  out  32  value written to mem[B]
- mmu_en  out  1  MMU access strobe
- mmu_we  out  1  write (1) / read (0)
- mmu_addr  out  ADDR_W  line address, bits [2:0] forced 0
- mmu_be_n  out  8  active-low byte enables (bit i = be{i}n)
- mmu_wdata  out  64  write data
- mmu_rdata  in  64  read data, valid the cycle after a read strobe

## Operation
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE: in_ready=1; on in_valid, latch op_a/op_b/op_c/pc_next -> RD_A.
- RD_A: mmu_en=1, we=0, addr={op_a[ADDR_W-1:3],3'b000}, be_n=8'h00 -> RD_B.
- RD_B: read strobe for op_b likewise; capture word A from mmu_rdata (op_a[2] ? [63:32] : [31:0]) -> WR.
- WR: capture word B from mmu_rdata; result = B − A, 32-bit wraparound; mmu_en=1, we=1, addr=op_b line; be_n=8'h0F if op_b[2] else 8'hF0; wdata={result,result}; register result, branch_taken, target -> DONE.
- DONE: out_valid=1; on out_ready -> IDLE.
- op_a/op_b bits [1:0] ignored (word aligned).
- branch_taken = result[31] | (result==0), evaluated on the wrapped result.
- MMU outputs decoded from state; in IDLE/DONE: mmu_en=0, we=0, be_n=8'hFF, addr and wdata 0.

## Timing
- Reset (async, any state): state=IDLE, out_valid=0, branch_taken=0, target=0, result=0, all MMU outputs at idle values; in_ready=1 once resetb is high. In-flight instruction discarded; a write in progress is dropped.
- Acceptance edge T0; RD_A in cycle T0+1, RD_B in T0+2, WR in T0+3, out_valid from T0+4. Throughput is one instruction per 5 cycles with out_ready held high.
- out_valid held with stable branch_taken/target/result until out_ready sampled high.
- in_valid in any non-IDLE state is ignored (in_ready=0).
- Same-line A/B (different halves) and A==B are legal; the second read returns the pre-write value.

## Configuration
- SUBLEQ_SAME_OPERAND_EN: when defined and op_a[ADDR_W-1:2]==op_b[ADDR_W-1:2] at acceptance, RD_B is skipped. The transition is RD_A -> WR, word A is used as both operands, and result is 0 (branch taken). out_valid rises at T0+3.
- Undefined: every instruction takes the full RD_A/RD_B/WR path.

## Test plan
- Reset mid-WR: resetb low during the write cycle -> mmu_en=0, be_n=8'hFF, out_valid=0 immediately; in_ready=1 after release.
- A=0x0008 holds 5, B=0x0014 holds 12, C=0x0100, pc_next=0x0040 -> write 7 to line 0x0010 with be_n=8'h0F, wdata=64'h00000007_00000007; branch_taken=0, target=0x0040.
- A=0x0000 holds 9, B=0x0004 holds 3 -> result 0xFFFFFFFA, be_n=8'h0F on line 0x0000, branch_taken=1, target=C.
- Wrap: A holds 0x00000001, B holds 0x80000000 -> result 0x7FFFFFFF, branch_taken=0.
- Backpressure: out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, no MMU strobes. Second instruction accepted the cycle after the handshake.
- A==B=0x0020 holding 42: with SUBLEQ_SAME_OPERAND_EN, one read, write 0, out_valid at T0+3. Without the macro, two reads, same write, out_valid at T0+4. branch_taken=1 in both cases.
